queue_reader: RTL and testbench
===============================

# queue_reader

Read-side drain engine for the team's `Queue` FIFO. It issues `rReq` pops into the FIFO, captures the registered `dout` one cycle later, and re-presents the words as a valid/ready stream through a 2-entry output buffer. It sits between a `Queue` instance and any downstream consumer, and runs at up to 1 word/cycle. A delivered-word counter and a controlled stop/drain sequence are included.

## Interface
- `WL`, 4, data word width; must match the FIFO's `WL`.
- `CW`, 8, width of the delivered-word counter.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `en` in 1: level; high = drain FIFO, low = stop after flushing in-flight data.
- `rReq` out 1: pop request to the FIFO.
- `q_dout` in WL: FIFO read data; valid the cycle after an accepted `rReq`.
- `q_EMPTY` in 1: FIFO empty flag.
- `q_ERROR` in 1: FIFO error flag.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out WL: output word (buffer head).
- `busy` out 1: state is not IDLE.
- `count` out CW: number of words delivered (`m_valid & m_ready`); wraps modulo 2^CW.
- `err` out 1: sticky underflow error (see Configuration).

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE→RUN when `en`=1.
  - RUN→DRAIN when `en`=0.
  - DRAIN→IDLE when `pend`=0 and `occ`=0.
  - DRAIN→RUN if `en` returns high.
- **Internal state:**
  - `occ`: 0..2 words held in the output buffer.
  - `pend`: 1-bit flag, "a read was issued last cycle".
- **Pop rule:** `rReq` = (state==RUN) & !`q_EMPTY` & (`occ` + `pend` − `pop`) < 2, where `pop` = `m_valid` & `m_ready`. Combinational. The buffer can never overflow.
- **Capture:** when `pend`=1, `q_dout` is written into the buffer tail at the clock edge.
- **Simultaneous capture and pop** in one cycle: `occ` is unchanged and the buffer shifts correctly.
- **Output:** `m_valid` = (`occ` != 0). `m_data` = head entry. `m_data` stays stable while `m_valid` & !`m_ready`.
- **Ordering:** words leave in exactly FIFO order; none are dropped or duplicated.
- **Counter:** `count` increments on every `pop`, including pops in DRAIN. From 2^CW−1 it wraps to 0.
- **Downstream in DRAIN:** buffered and pending words are still delivered; no new `rReq` is issued.

## Timing
- **Reset values:** `rReq`=0, `m_valid`=0, `m_data`=0, `busy`=0, `count`=0, `err`=0; state IDLE, `occ`=0, `pend`=0.
- **Reset mid-operation:** asynchronous; all in-flight and buffered words are discarded immediately.
- **Latency:** `rReq` high in cycle t → `pend`=1 in t+1 → `m_valid`=1 in t+2 (if the buffer was empty).
- **Throughput:** with `m_ready` held high and the FIFO non-empty, 1 word/cycle is sustained after the 2-cycle fill.
- **Backpressure:** with `m_ready` low, at most 2 words are buffered. `rReq` goes low once `occ` + `pend` reaches 2.
- **Empty FIFO:** `rReq` stays 0 while `q_EMPTY`=1; no stall state is needed.
- **`busy`:** registered and follows the state; it falls on the cycle after the last word is popped in DRAIN.

## Configuration
- **`QUEUE_READER_ERRCHK_EN` defined:**
  - `q_ERROR` is sampled when `pend`=1.
  - If it is 1, the captured word is discarded (not written), `err` is set sticky, and state goes to DRAIN.
  - `err` clears only on reset.
- **Macro undefined:** `err` is tied to 0, `q_ERROR` is ignored, and every pending word is captured.

## Structure
- **Shared package `queue_pkg`:**
  - State enum constants `QR_IDLE`=2'd0, `QR_RUN`=2'd1, `QR_DRAIN`=2'd2.
  - Buffer depth constant `QR_BUF_DEPTH`=2.
- **One sub-module, `qr_skid_buf`:** the 2-entry buffer with head/tail, `occ`, and push/pop.
- **Top level** holds the FSM, the pop rule, `pend`, and the counter.

## Test plan
- **Steady stream:** reset, preload the FIFO with 4, 5, 6, 7, `en`=1, `m_ready`=1 → `m_data` 4, 5, 6, 7 on consecutive cycles, first `m_valid` 2 cycles after the first `rReq`; `count`=4.
- **Backpressure:** 4 words loaded, `m_ready`=0 → `rReq` pulses exactly twice, `m_valid`=1, `m_data` holds the first word; release `m_ready` → remaining words arrive in order.
- **Empty FIFO:** `en`=1 with the FIFO empty → `rReq`=0, `m_valid`=0, `busy`=1; push 9 → `m_data`=9 appears.
- **Stop mid-stream:** drop `en` the cycle after an `rReq` → that pending word is still delivered, then `busy`=0, no further `rReq`.
- **Async reset:** assert `RST` low with `occ`=2 → all outputs go to reset values before the next clock edge; `count`=0.
- **`count` wrap (CW=2):** deliver 5 words → `count` reads 1. With `QUEUE_READER_ERRCHK_EN` defined, force `q_ERROR`=1 on a pend cycle → `err`=1, the word is dropped, state reaches IDLE.

Source files
------------

// File: rtl/queue_pkg.sv
// queue_pkg: shared definitions for the Queue read-side drain engine.
//   qr_state_t   - FSM state encoding (IDLE / RUN / DRAIN)
//   QR_BUF_DEPTH - entries in the output skid buffer
//   qr_has_room  - pop-rule headroom test used by the reader
package queue_pkg;

    typedef enum logic [1:0] {
        QR_IDLE  = 2'd0,
        QR_RUN   = 2'd1,
        QR_DRAIN = 2'd2
    } qr_state_t;

    localparam int QR_BUF_DEPTH = 2;

    // True when one more read can be issued without overflowing the buffer:
    // words held + word in flight - word leaving this cycle < depth.
    function automatic logic qr_has_room(input logic [1:0] occ,
                                         input logic       pend,
                                         input logic       pop);
        logic [2:0] lvl;
        logic [2:0] lim;
        lvl = {1'b0, occ} + {2'b00, pend};
        lim = 3'(QR_BUF_DEPTH) + {2'b00, pop};
        return lvl < lim;
    endfunction

endpackage

// File: rtl/qr_skid_buf.sv
// qr_skid_buf: 2-entry in-order output buffer for queue_reader.
// Ports:
//   CLK, RST     - clock, async active-low reset
//   push, din    - write din at the tail
//   pop          - drop the head entry
//   head         - current head word (reads 0 after reset)
//   occ          - number of valid entries, 0..2
// Caller guarantees no push when full and no pop when empty.
module qr_skid_buf
    import queue_pkg::*;
#(
    parameter int WL = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [WL-1:0] din,
    input  logic          pop,
    output logic [WL-1:0] head,
    output logic [1:0]    occ
);

    logic [WL-1:0] tail;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    // Keep head unchanged when emptying so m_data does not glitch.
                    if (occ == 2'(QR_BUF_DEPTH)) head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind the survivor.
                    if (occ == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/queue_reader.sv
// queue_reader: drains a Queue FIFO (registered dout, 1-cycle read latency)
// and re-presents the words as a valid/ready stream.
// Ports:
//   CLK, RST           - clock, async active-low reset
//   en                 - level: 1 = drain the FIFO, 0 = stop after in-flight data
//   rReq               - pop request to the FIFO (combinational)
//   q_dout             - FIFO read data, valid the cycle after rReq
//   q_EMPTY, q_ERROR   - FIFO status flags
//   m_valid/m_ready/m_data - output stream
//   busy               - state is not IDLE
//   count              - delivered words, wraps modulo 2^CW
//   err                - sticky read error
// Optional: define QUEUE_READER_ERRCHK_EN to discard words read while
// q_ERROR is high, set err, and stop the reader. Without it err is 0.
module queue_reader
    import queue_pkg::*;
#(
    parameter int WL = 4,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    output logic          rReq,
    input  logic [WL-1:0] q_dout,
    input  logic          q_EMPTY,
    input  logic          q_ERROR,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [WL-1:0] m_data,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          err
);

    qr_state_t  state, state_nxt;
    logic       pend;
    logic       pop;
    logic       push;
    logic       cap_err;
    logic       drained;
    logic [1:0] occ;

    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != 2'd0);
    assign busy    = (state != QR_IDLE);

`ifdef QUEUE_READER_ERRCHK_EN
    assign cap_err = pend & q_ERROR;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         err <= 1'b0;
        else if (cap_err) err <= 1'b1;
    end
`else
    logic unused_q_error;
    assign unused_q_error = q_ERROR;
    assign cap_err        = 1'b0;
    assign err            = 1'b0;
`endif

    assign push = pend & ~cap_err;

    // Buffer empties at this edge: nothing in flight and any last word leaving.
    assign drained = ~pend & ((occ == 2'd0) | ((occ == 2'd1) & pop));

    qr_skid_buf #(.WL(WL)) u_buf (
        .CLK  (CLK),
        .RST  (RST),
        .push (push),
        .din  (q_dout),
        .pop  (pop),
        .head (m_data),
        .occ  (occ)
    );

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= QR_IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state. A sticky error keeps the reader from restarting.
    always_comb begin
        state_nxt = state;
        case (state)
            QR_IDLE:  if (en && !err) state_nxt = QR_RUN;
            QR_RUN:   if (cap_err || !en) state_nxt = QR_DRAIN;
            QR_DRAIN: begin
                if (en && !err && !cap_err) state_nxt = QR_RUN;
                else if (drained)           state_nxt = QR_IDLE;
            end
            default:  state_nxt = QR_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rReq = 1'b0;
        if (state == QR_RUN && !q_EMPTY)
            rReq = qr_has_room(occ, pend, pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend  <= 1'b0;
            count <= '0;
        end else begin
            pend <= rReq;
            if (pop) count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
module tb_queue_reader;

    localparam int WL = 4;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          en = 1'b0;
    logic          rReq;
    logic [WL-1:0] q_dout = '0;
    logic          q_EMPTY;
    logic          q_ERROR = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [WL-1:0] m_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WL-1:0] fifo[$];

    always #5 CLK = ~CLK;

    queue_reader #(.WL(WL), .CW(CW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .rReq    (rReq),
        .q_dout  (q_dout),
        .q_EMPTY (q_EMPTY),
        .q_ERROR (q_ERROR),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .busy    (busy),
        .count   (count),
        .err     (err)
    );

    // FIFO model: registered dout, one word per accepted rReq.
    assign q_EMPTY = (fifo.size() == 0);
    always @(posedge CLK)
        if (rReq && fifo.size() > 0) q_dout <= fifo.pop_front();

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        q_ERROR = 1'b0;
        fifo.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        int k;
        logic seen;

        // Reset values
        #2;
        chk("rst_rreq", rReq, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);

        // Steady stream: 4,5,6,7 on consecutive cycles, 2-cycle fill
        do_reset();
        for (int i = 4; i < 8; i++) fifo.push_back(WL'(i));
        en = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("ss_idle_rreq", rReq, 0);
        cyc();
        chk("ss_rreq_first", rReq, 1);
        chk("ss_nv_t", m_valid, 0);
        cyc();
        chk("ss_nv_t1", m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ss_valid", m_valid, 1);
            chk("ss_data", m_data, 4 + i);
        end
        cyc();
        chk("ss_done_valid", m_valid, 0);
        chk("ss_count", count, 4);

        // Backpressure: two reads max, head held, then ordered release
        do_reset();
        for (int i = 10; i < 14; i++) fifo.push_back(WL'(i));
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rReq) n++;
            if (i >= 3) chk("bp_hold", m_data, 10);
        end
        chk("bp_pulses", n, 2);
        chk("bp_valid", m_valid, 1);
        m_ready = 1'b1;
        #1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_valid && m_ready) begin
                chk("bp_order", m_data, 10 + k);
                k++;
            end
            cyc();
        end
        chk("bp_delivered", k, 4);
        chk("bp_count", count, 4);

        // Empty FIFO: running but idle, then one word arrives
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        repeat (3) cyc();
        chk("emp_rreq", rReq, 0);
        chk("emp_valid", m_valid, 0);
        chk("emp_busy", busy, 1);
        fifo.push_back(WL'(9));
        #1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        chk("emp_seen", seen, 1);
        chk("emp_data", m_data, 9);

        // Stop mid-stream: the in-flight word is still delivered
        do_reset();
        for (int i = 20; i < 23; i++) fifo.push_back(WL'(i));
        en = 1'b1;
        m_ready = 1'b1;
        cyc();
        chk("stop_rreq", rReq, 1);
        en = 1'b0;
        cyc();
        chk("stop_rreq_off", rReq, 0);
        chk("stop_busy_b", busy, 1);
        cyc();
        chk("stop_valid", m_valid, 1);
        chk("stop_data", m_data, 20 & 4'hf);
        chk("stop_busy_c", busy, 1);
        cyc();
        chk("stop_busy_off", busy, 0);
        chk("stop_valid_off", m_valid, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (rReq) n++;
        end
        chk("stop_no_rreq", n, 0);
        chk("stop_count", count, 1);
        chk("stop_fifo_left", fifo.size(), 2);

        // Async reset with a full buffer
        do_reset();
        for (int i = 1; i < 6; i++) fifo.push_back(WL'(i));
        en = 1'b1;
        m_ready = 1'b1;
        repeat (4) cyc();
        m_ready = 1'b0;
        repeat (4) cyc();
        chk("ar_pre_valid", m_valid, 1);
        chk("ar_pre_cnt_nz", count != 0, 1);
        RST = 1'b0;
        #1;
        chk("ar_rreq", rReq, 0);
        chk("ar_valid", m_valid, 0);
        chk("ar_data", m_data, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", count, 0);

        // Counter wrap: 257 words through an 8-bit counter
        do_reset();
        for (int i = 0; i < 257; i++) fifo.push_back(WL'(i));
        en = 1'b1;
        m_ready = 1'b1;
        #1;
        k = 0;
        for (int i = 0; i < 400 && k < 257; i++) begin
            if (m_valid && m_ready) begin
                chk("wrap_order", m_data, k % 16);
                k++;
            end
            cyc();
        end
        chk("wrap_delivered", k, 257);
        chk("wrap_count", count, 1);

`ifdef QUEUE_READER_ERRCHK_EN
        // Read error: word dropped, err sticky, reader returns to IDLE
        do_reset();
        fifo.push_back(WL'(3));
        fifo.push_back(WL'(4));
        en = 1'b1;
        m_ready = 1'b1;
        cyc();
        chk("er_rreq", rReq, 1);
        en = 1'b0;
        cyc();
        q_ERROR = 1'b1;
        cyc();
        q_ERROR = 1'b0;
        chk("er_err", err, 1);
        chk("er_dropped", m_valid, 0);
        cyc();
        chk("er_idle", busy, 0);
        chk("er_count", count, 0);
        repeat (2) cyc();
        chk("er_sticky", err, 1);
`else
        chk("noerr_err", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
